uart_frame_ctrl: RTL and testbench

Frame-level receive controller that sits directly behind the UART receiver and sequences its byte stream into validated packets.
- Packet format: SYNC, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
- Payload is buffered in an internal register file; a completed frame is handed to the consumer with a valid/ack handshake.
- On receiver error or inter-byte timeout, the block drives the receiver's reset to resynchronise it, and counts dropped frames/bytes.

---
 rtl/uart_frame_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// Frame-level receive controller behind a UART receiver.
// Hunts for SYNC, collects LEN and payload, verifies the XOR checksum and holds
// a good frame for the consumer until it is acknowledged. Receiver errors and
// inter-byte timeouts pulse the receiver reset and count the lost frame.
module uart_frame_ctrl #(
    parameter int unsigned TIMEOUT_CLKS = 4340,
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned RESYNC_CLKS  = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rxStrobe,
    input  logic [7:0] i_rxByte,
    input  logic       i_rxError,
    output logic       o_rxReset,
    output logic       o_frameValid,
    input  logic       i_frameAck,
    output logic [4:0] o_frameLen,
    input  logic [4:0] i_rdAddr,
    output logic [7:0] o_rdData,
    output logic       o_crcError,
    output logic       o_timeoutError,
    output logic [7:0] o_dropCount
);

    typedef enum logic [2:0] {
        StHunt,
        StLen,
        StPayload,
        StCheck,
        StHold,
        StResync
    } state_t;

    localparam logic [7:0]  MaxLenByte = 8'(MAX_LEN);
    localparam logic [4:0]  MaxLenAddr = 5'(MAX_LEN);
    localparam logic [16:0] ToLimit    = 17'(TIMEOUT_CLKS - 1);
    localparam logic [15:0] ResyncLast = 16'(RESYNC_CLKS - 1);

    state_t      state;
    logic [4:0]  idx;
    logic [7:0]  chk;
    logic [15:0] toCnt;
    logic [15:0] rsCnt;
    // 32 entries so any 5-bit address indexes safely; only MAX_LEN are ever used.
    logic [7:0]  buffer [32];

    logic [16:0] toCntInc;
    logic        toExpire;
    logic        dropEvent;
    logic        bufWe;

    assign toCntInc = {1'b0, toCnt} + 17'd1;
    // The idle cycle that would bring the counter to TIMEOUT_CLKS-1 fires the timeout.
    assign toExpire = (toCntInc >= ToLimit);

    // Decode which cycles discard data and which write the payload buffer.
    always_comb begin
        dropEvent = 1'b0;
        bufWe     = 1'b0;
        if (!i_reset) begin
            case (state)
                StLen, StPayload, StCheck: begin
                    if (i_rxError) begin
                        dropEvent = 1'b1;
                    end else if (i_rxStrobe) begin
                        case (state)
                            StLen:     dropEvent = (i_rxByte == 8'd0) || (i_rxByte > MaxLenByte);
                            StPayload: bufWe = 1'b1;
                            default:   dropEvent = (i_rxByte != chk);
                        endcase
                    end else begin
                        dropEvent = toExpire;
                    end
                end
                StHold:  dropEvent = i_rxStrobe;
                default: ;
            endcase
        end
    end

    // Frame sequencing FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= StHunt;
            idx            <= 5'd0;
            chk            <= 8'd0;
            toCnt          <= 16'd0;
            rsCnt          <= 16'd0;
            o_rxReset      <= 1'b0;
            o_frameValid   <= 1'b0;
            o_frameLen     <= 5'd0;
            o_crcError     <= 1'b0;
            o_timeoutError <= 1'b0;
            o_dropCount    <= 8'd0;
        end else begin
            o_crcError     <= 1'b0;
            o_timeoutError <= 1'b0;
            if (dropEvent && (o_dropCount != 8'hFF)) begin
                o_dropCount <= o_dropCount + 8'd1;
            end
            case (state)
                StHunt: begin
                    if (i_rxError) begin
                        state     <= StResync;
                        o_rxReset <= 1'b1;
                        rsCnt     <= 16'd0;
                    end else if (i_rxStrobe && (i_rxByte == SYNC_BYTE)) begin
                        state <= StLen;
                        toCnt <= 16'd0;
                    end
                end
                StLen, StPayload, StCheck: begin
                    if (i_rxError) begin
                        state     <= StResync;
                        o_rxReset <= 1'b1;
                        rsCnt     <= 16'd0;
                    end else if (i_rxStrobe) begin
                        toCnt <= 16'd0;
                        case (state)
                            StLen: begin
                                if ((i_rxByte == 8'd0) || (i_rxByte > MaxLenByte)) begin
                                    state <= StHunt;
                                end else begin
                                    o_frameLen <= i_rxByte[4:0];
                                    chk        <= i_rxByte;
                                    idx        <= 5'd0;
                                    state      <= StPayload;
                                end
                            end
                            StPayload: begin
                                chk <= chk ^ i_rxByte;
                                idx <= idx + 5'd1;
                                if (idx == (o_frameLen - 5'd1)) begin
                                    state <= StCheck;
                                end
                            end
                            default: begin
                                if (i_rxByte == chk) begin
                                    state        <= StHold;
                                    o_frameValid <= 1'b1;
                                end else begin
                                    state      <= StHunt;
                                    o_crcError <= 1'b1;
                                end
                            end
                        endcase
                    end else if (toExpire) begin
                        o_timeoutError <= 1'b1;
                        state          <= StResync;
                        o_rxReset      <= 1'b1;
                        rsCnt          <= 16'd0;
                    end else begin
                        toCnt <= toCntInc[15:0];
                    end
                end
                StHold: begin
                    if (i_frameAck) begin
                        state        <= StHunt;
                        o_frameValid <= 1'b0;
                    end
                end
                StResync: begin
                    if (rsCnt == ResyncLast) begin
                        state     <= StHunt;
                        o_rxReset <= 1'b0;
                    end else begin
                        rsCnt <= rsCnt + 16'd1;
                    end
                end
                default: state <= StHunt;
            endcase
        end
    end

    // Payload storage; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (bufWe) begin
            buffer[idx] <= i_rxByte;
        end
    end

    // Registered read port, one cycle latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rdData <= 8'd0;
        end else begin
            o_rdData <= (i_rdAddr < MaxLenAddr) ? buffer[i_rdAddr] : 8'd0;
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed vector table, hand-written corner cases
// and a randomized byte stream checked every cycle against a frame-level model.
module tb_uart_frame_ctrl;

    localparam int unsigned TO     = 40;
    localparam int unsigned MAXL   = 16;
    localparam int unsigned RESYNC = 2;
    localparam logic [7:0]  SYNC   = 8'hA5;

    logic       clk;
    logic       rst;
    logic       stb;
    logic [7:0] byteIn;
    logic       err;
    logic       ack;
    logic [4:0] addr;
    logic       o_rxReset;
    logic       o_frameValid;
    logic [4:0] o_frameLen;
    logic [7:0] o_rdData;
    logic       o_crcError;
    logic       o_timeoutError;
    logic [7:0] o_dropCount;

    int nVec = 0;
    int nFail = 0;

    uart_frame_ctrl #(
        .TIMEOUT_CLKS(TO),
        .MAX_LEN     (MAXL),
        .SYNC_BYTE   (SYNC),
        .RESYNC_CLKS (RESYNC)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_rxStrobe    (stb),
        .i_rxByte      (byteIn),
        .i_rxError     (err),
        .o_rxReset     (o_rxReset),
        .o_frameValid  (o_frameValid),
        .i_frameAck    (ack),
        .o_frameLen    (o_frameLen),
        .i_rdAddr      (addr),
        .o_rdData      (o_rdData),
        .o_crcError    (o_crcError),
        .o_timeoutError(o_timeoutError),
        .o_dropCount   (o_dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model: bytes since SYNC kept in a queue, checksum as XOR over it.
    bit         mInFrame;
    bit         mHold;
    int         mResync;
    int         mIdle;
    int         mLen;
    logic [7:0] mFrame[$];
    bit         mValid;
    logic [4:0] mFrameLen;
    int         mDrop;
    bit         mCrc;
    bit         mTo;
    logic [7:0] mRd;
    bit         mRdKnown;
    logic [7:0] mMem[32];
    bit         mKnown[32];

    task automatic mdlAbandon(bit toResync);
        mInFrame = 0;
        if (toResync) mResync = RESYNC;
    endtask

    task automatic mdlEdge();
        bit drop = 0;
        logic [7:0] x;
        int n;
        mCrc = 0;
        mTo  = 0;
        if (addr < MAXL && mKnown[addr]) begin
            mRd = mMem[addr];
            mRdKnown = 1;
        end else begin
            mRdKnown = 0;
        end
        if (rst) begin
            mInFrame = 0; mHold = 0; mResync = 0; mIdle = 0;
            mValid = 0; mFrameLen = 0; mDrop = 0; mRd = 0; mRdKnown = 1;
            return;
        end
        if (mResync > 0) begin
            mResync--;
        end else if (mHold) begin
            if (stb) drop = 1;
            if (ack) begin
                mHold = 0;
                mValid = 0;
            end
        end else if (!mInFrame) begin
            if (err) begin
                mResync = RESYNC;
            end else if (stb && byteIn == SYNC) begin
                mInFrame = 1;
                mFrame.delete();
                mIdle = 0;
            end
        end else if (err) begin
            drop = 1;
            mdlAbandon(1);
        end else if (stb) begin
            mIdle = 0;
            mFrame.push_back(byteIn);
            n = mFrame.size();
            if (n == 1) begin
                if (byteIn == 0 || byteIn > MAXL) begin
                    drop = 1;
                    mdlAbandon(0);
                end else begin
                    mLen = int'(byteIn);
                    mFrameLen = byteIn[4:0];
                end
            end else if (n <= mLen + 1) begin
                mMem[n-2] = byteIn;
                mKnown[n-2] = 1;
            end else begin
                x = 8'h00;
                foreach (mFrame[i]) x ^= mFrame[i];
                if (x == 8'h00) begin
                    mHold = 1;
                    mValid = 1;
                    mInFrame = 0;
                end else begin
                    mCrc = 1;
                    drop = 1;
                    mdlAbandon(0);
                end
            end
        end else begin
            mIdle++;
            if (mIdle >= int'(TO) - 1) begin
                mTo = 1;
                drop = 1;
                mdlAbandon(1);
            end
        end
        if (drop && mDrop < 255) mDrop++;
    endtask

    task automatic step();
        @(posedge clk);
        mdlEdge();
        #1;
        nVec++;
        if (o_frameValid !== mValid || o_frameLen !== mFrameLen || o_rxReset !== (mResync > 0)
            || o_crcError !== mCrc || o_timeoutError !== mTo || o_dropCount !== 8'(mDrop)
            || (mRdKnown && o_rdData !== mRd)) begin
            nFail++;
            $display("FAIL model t=%0t: v/len/rr/crc/to/drop/rd got %b %0d %b %b %b %0d %h want %b %0d %b %b %b %0d %h(known=%b)",
                     $time, o_frameValid, o_frameLen, o_rxReset, o_crcError, o_timeoutError,
                     o_dropCount, o_rdData, mValid, mFrameLen, (mResync > 0), mCrc, mTo, mDrop,
                     mRd, mRdKnown);
        end
    endtask

    task automatic expectVal(string name, int act, int exp);
        nVec++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic send(logic [7:0] b);
        stb = 1; byteIn = b;
        step();
        stb = 0;
    endtask

    // Counts consecutive cycles (from now) that o_rxReset stays high.
    task automatic countRxReset(output int rr);
        rr = 0;
        while (o_rxReset === 1'b1 && rr < 20) begin
            rr++;
            step();
        end
    endtask

    typedef struct {
        bit         rst;
        bit         stb;
        logic [7:0] data;
        bit         ack;
        logic [4:0] addr;
        bit         eValid;
        logic [4:0] eLen;
        logic [7:0] eDrop;
        bit         eCrc;
        bit         chkRd;
        logic [7:0] eRd;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t row(bit r, bit s, logic [7:0] d, bit a, logic [4:0] ad, bit v,
                                 logic [4:0] l, logic [7:0] dr, bit c, bit cr, logic [7:0] rd);
        vec_t t;
        t.rst = r; t.stb = s; t.data = d; t.ack = a; t.addr = ad; t.eValid = v;
        t.eLen = l; t.eDrop = dr; t.eCrc = c; t.chkRd = cr; t.eRd = rd;
        return t;
    endfunction

    initial begin
        int cnt;
        int rr;
        bit seen;
        int gap;
        int errLeft;
        int r;
        int len;
        logic [7:0] c;
        logic [7:0] txq[$];

        rst = 1; stb = 0; byteIn = 0; err = 0; ack = 0; addr = 0;

        //             rst stb data  ack adr val len drop crc chkRd rd
        tbl[0]  = row(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[1]  = row(0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[2]  = row(0, 1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[3]  = row(0, 1, 8'h03, 0, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[4]  = row(0, 1, 8'h11, 0, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[5]  = row(0, 1, 8'h22, 0, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[6]  = row(0, 1, 8'h33, 0, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[7]  = row(0, 1, 8'h03, 0, 0, 1, 3, 0, 0, 0, 8'h00);
        tbl[8]  = row(0, 0, 8'h00, 0, 0, 1, 3, 0, 0, 1, 8'h11);
        tbl[9]  = row(0, 0, 8'h00, 0, 1, 1, 3, 0, 0, 1, 8'h22);
        tbl[10] = row(0, 0, 8'h00, 0, 2, 1, 3, 0, 0, 1, 8'h33);
        tbl[11] = row(0, 0, 8'h00, 1, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[12] = row(0, 0, 8'h00, 0, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[13] = row(0, 1, 8'hA5, 0, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[14] = row(0, 1, 8'h03, 0, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[15] = row(0, 1, 8'h11, 0, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[16] = row(0, 1, 8'h22, 0, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[17] = row(0, 1, 8'h33, 0, 0, 0, 3, 0, 0, 0, 8'h00);
        tbl[18] = row(0, 1, 8'h04, 0, 0, 0, 3, 1, 1, 0, 8'h00);
        tbl[19] = row(0, 0, 8'h00, 0, 0, 0, 3, 1, 0, 0, 8'h00);
        tbl[20] = row(0, 1, 8'hA5, 0, 0, 0, 3, 1, 0, 0, 8'h00);
        tbl[21] = row(0, 1, 8'h01, 0, 0, 0, 1, 1, 0, 0, 8'h00);
        tbl[22] = row(0, 1, 8'h7E, 0, 0, 0, 1, 1, 0, 0, 8'h00);
        tbl[23] = row(0, 1, 8'h7F, 0, 0, 1, 1, 1, 0, 0, 8'h00);
        tbl[24] = row(0, 0, 8'h00, 1, 0, 0, 1, 1, 0, 0, 8'h00);
        tbl[25] = row(0, 1, 8'hA5, 0, 0, 0, 1, 1, 0, 0, 8'h00);
        tbl[26] = row(0, 1, 8'h00, 0, 0, 0, 1, 2, 0, 0, 8'h00);
        tbl[27] = row(0, 1, 8'hA5, 0, 0, 0, 1, 2, 0, 0, 8'h00);
        tbl[28] = row(0, 1, 8'h11, 0, 0, 0, 1, 3, 0, 0, 8'h00);

        #2;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; stb = tbl[i].stb; byteIn = tbl[i].data;
            ack = tbl[i].ack; addr = tbl[i].addr;
            step();
            nVec++;
            if (o_frameValid !== tbl[i].eValid || o_frameLen !== tbl[i].eLen
                || o_dropCount !== tbl[i].eDrop || o_crcError !== tbl[i].eCrc
                || o_timeoutError !== 1'b0 || o_rxReset !== 1'b0
                || (tbl[i].chkRd && o_rdData !== tbl[i].eRd)) begin
                nFail++;
                $display("FAIL table[%0d]: v/len/drop/crc/to/rr/rd got %b %0d %0d %b %b %b %h want %b %0d %0d %b 0 0 %h",
                         i, o_frameValid, o_frameLen, o_dropCount, o_crcError, o_timeoutError,
                         o_rxReset, o_rdData, tbl[i].eValid, tbl[i].eLen, tbl[i].eDrop,
                         tbl[i].eCrc, tbl[i].eRd);
            end
        end
        rst = 0; stb = 0; ack = 0; addr = 0;

        // Timeout inside PAYLOAD: pulse TO-1 cycles after the last strobe.
        send(8'hA5); send(8'h02); send(8'h11);
        cnt = 0; seen = 0;
        while (!seen && cnt < int'(TO) + 10) begin
            step();
            cnt++;
            if (o_timeoutError === 1'b1) seen = 1;
        end
        expectVal("timeout latency", cnt, int'(TO) - 1);
        countRxReset(rr);
        expectVal("timeout rxReset width", rr, 2);
        expectVal("timeout drop", int'(o_dropCount), 4);

        // Strobes while a frame is held are dropped; the buffer stays frozen.
        send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
        expectVal("hold valid", int'(o_frameValid), 1);
        send(8'h5A); send(8'h6B);
        expectVal("hold drops", int'(o_dropCount), 6);
        addr = 0; step();
        expectVal("hold rd0", int'(o_rdData), 8'hAA);
        addr = 1; step();
        expectVal("hold rd1", int'(o_rdData), 8'hBB);
        ack = 1; step(); ack = 0;
        expectVal("ack clears valid", int'(o_frameValid), 0);
        send(8'hA5); send(8'h01); send(8'h5C); send(8'h5D);
        expectVal("post-ack frame valid", int'(o_frameValid), 1);
        expectVal("post-ack frame len", int'(o_frameLen), 1);
        ack = 1; step(); ack = 0;

        // Receiver error with a coincident strobe mid-PAYLOAD.
        send(8'hA5); send(8'h04); send(8'h01);
        stb = 1; byteIn = 8'h02; err = 1;
        step();
        stb = 0; err = 0;
        countRxReset(rr);
        expectVal("rxError rxReset width", rr, 2);
        expectVal("rxError drop", int'(o_dropCount), 7);
        addr = 1; step();
        expectVal("rxError byte discarded", int'(o_rdData), 8'hBB);

        // Reset mid-PAYLOAD clears every output.
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        rst = 1; step(); rst = 0;
        expectVal("reset valid", int'(o_frameValid), 0);
        expectVal("reset len", int'(o_frameLen), 0);
        expectVal("reset drop", int'(o_dropCount), 0);
        expectVal("reset rd", int'(o_rdData), 0);

        // Randomized stream of good, corrupt, oversize and truncated frames.
        gap = 0; errLeft = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            rst = ($urandom_range(0, 999) == 0);
            stb = 0;
            if (errLeft > 0) begin
                err = 1; errLeft--;
            end else begin
                err = 0;
                if ($urandom_range(0, 249) == 0) errLeft = $urandom_range(1, 3);
            end
            ack = ($urandom_range(0, 3) == 0);
            addr = 5'($urandom_range(0, 31));
            if (gap > 0) begin
                gap--;
            end else if (txq.size() == 0) begin
                if ($urandom_range(0, 3) == 0) txq.push_back(8'($urandom_range(0, 255)));
                txq.push_back(SYNC);
                r = $urandom_range(0, 99);
                if (r < 5) len = 0;
                else if (r < 10) len = $urandom_range(MAXL + 1, 40);
                else len = $urandom_range(1, MAXL);
                txq.push_back(8'(len));
                c = 8'(len);
                for (int k = 0; k < ((len > int'(MAXL)) ? 3 : len); k++) begin
                    txq.push_back(8'($urandom_range(0, 255)));
                    c ^= txq[txq.size()-1];
                end
                if ($urandom_range(0, 6) == 0) c ^= 8'(1 << $urandom_range(0, 7));
                txq.push_back(c);
                if ($urandom_range(0, 9) == 0) begin
                    for (int k = 0; k < $urandom_range(1, 3); k++) begin
                        if (txq.size() > 1) void'(txq.pop_back());
                    end
                end
            end else begin
                stb = 1;
                byteIn = txq.pop_front();
                r = $urandom_range(0, 99);
                if (r < 60) gap = 0;
                else if (r < 95) gap = $urandom_range(1, 5);
                else gap = $urandom_range(TO - 3, TO + 2);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
